// File: rtl/dcache_pkg.sv
// Shared types and address-geometry constants for the direct-mapped data cache.
// INDEX_W/TAG_W describe the default 32-line geometry; tag entries carry the widest possible tag.
package dcache_pkg;

   localparam int ADDR_W    = 32;
   localparam int WORD_W    = 32;
   localparam int OFFSET_W  = 5;
   localparam int INDEX_W   = 5;
   localparam int TAG_W     = ADDR_W - OFFSET_W - INDEX_W;
   localparam int TAG_MAX_W = ADDR_W - OFFSET_W;

   typedef enum logic [2:0] {
      IDLE,
      MISS,
      WRITEBACK,
      ALLOCATE,
      RETRY
   } state_t;

   typedef struct packed {
      logic                 valid;
      logic                 dirty;
      logic [TAG_MAX_W-1:0] tag;
   } tag_entry_t;

   // Tag bits above the index, zero-extended to the stored tag width.
   function automatic logic [TAG_MAX_W-1:0] tag_of(
      input logic [ADDR_W-1:0] addr,
      input int                idx_w
   );
      return TAG_MAX_W'(addr >> (OFFSET_W + idx_w));
   endfunction

endpackage

// File: rtl/dcache_sram.sv
// Single-port tag and data arrays: asynchronous read, synchronous write.
// Valid/dirty bits clear on reset; tag and data contents are left untouched.
module dcache_sram
   import dcache_pkg::*;
#(
   parameter int LINES     = 32,
   parameter int LINE_BITS = 256,
   parameter int IDX_W     = $clog2(LINES)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [IDX_W-1:0]     idx_i,
   input  logic                 we_i,
   input  tag_entry_t           wtag_i,
   input  logic [LINE_BITS-1:0] wdata_i,
   output tag_entry_t           rtag_o,
   output logic [LINE_BITS-1:0] rdata_o
);

   logic [LINES-1:0]     valid_q;
   logic [LINES-1:0]     dirty_q;
   logic [TAG_MAX_W-1:0] tag_q  [LINES];
   logic [LINE_BITS-1:0] data_q [LINES];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (we_i) begin
         valid_q[idx_i] <= wtag_i.valid;
         dirty_q[idx_i] <= wtag_i.dirty;
      end
   end

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         tag_q[idx_i]  <= wtag_i.tag;
         data_q[idx_i] <= wdata_i;
      end
   end

   always_comb begin
      rtag_o.valid = valid_q[idx_i];
      rtag_o.dirty = dirty_q[idx_i];
      rtag_o.tag   = tag_q[idx_i];
      rdata_o      = data_q[idx_i];
   end

endmodule

// File: rtl/dcache_ctrl.sv
// Write-back, write-allocate direct-mapped data cache controller.
// Define DCACHE_STATS_EN to add saturating hit/miss counters.
module dcache_ctrl
   import dcache_pkg::*;
#(
   parameter int LINES     = 32,
   parameter int LINE_BITS = 256
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [ADDR_W-1:0]    cpu_addr_i,
   input  logic [WORD_W-1:0]    cpu_data_i,
   input  logic                 cpu_MemRd_i,
   input  logic                 cpu_MemWr_i,
   output logic [WORD_W-1:0]    cpu_data_o,
   output logic                 cpu_stall_o,
   output logic [ADDR_W-1:0]    mem_addr_o,
   output logic [LINE_BITS-1:0] mem_data_o,
   output logic                 mem_enable_o,
   output logic                 mem_write_o,
   input  logic [LINE_BITS-1:0] mem_data_i,
   input  logic                 mem_ack_i
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0]          hit_count_o,
   output logic [31:0]          miss_count_o
`endif
);

   localparam int IDX_W = $clog2(LINES);
   localparam int TG_W  = ADDR_W - OFFSET_W - IDX_W;
   localparam int WORDS = LINE_BITS / WORD_W;
   localparam int SEL_W = $clog2(WORDS);

   state_t state_q, state_d;

   logic                 req;
   logic                 is_store;
   logic                 hit;
   logic [IDX_W-1:0]     idx;
   logic [SEL_W-1:0]     sel;
   logic [TAG_MAX_W-1:0] req_tag;
   logic [ADDR_W-1:0]    victim_addr;
   logic [ADDR_W-1:0]    fill_addr;
   logic [WORD_W-1:0]    rword;
   logic [LINE_BITS-1:0] merged;

   tag_entry_t           rtag;
   tag_entry_t           wtag;
   logic [LINE_BITS-1:0] rline;
   logic [LINE_BITS-1:0] wline;
   logic                 we;
   logic                 hit_evt;
   logic                 miss_evt;
   logic                 unused_bits;

   assign is_store    = cpu_MemWr_i;
   assign req         = cpu_MemRd_i | cpu_MemWr_i;
   assign idx         = cpu_addr_i[OFFSET_W +: IDX_W];
   assign sel         = cpu_addr_i[2 +: SEL_W];
   assign req_tag     = tag_of(cpu_addr_i, IDX_W);
   assign unused_bits = ^cpu_addr_i[1:0];

   assign hit = req && rtag.valid && (rtag.tag == req_tag);

   assign victim_addr = {rtag.tag[TG_W-1:0], idx, {OFFSET_W{1'b0}}};
   assign fill_addr   = {cpu_addr_i[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
   assign rword       = rline[sel*WORD_W +: WORD_W];

   always_comb begin
      merged = rline;
      merged[sel*WORD_W +: WORD_W] = cpu_data_i;
   end

   dcache_sram #(
      .LINES     (LINES),
      .LINE_BITS (LINE_BITS),
      .IDX_W     (IDX_W)
   ) u_sram (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .idx_i   (idx),
      .we_i    (we),
      .wtag_i  (wtag),
      .wdata_i (wline),
      .rtag_o  (rtag),
      .rdata_o (rline)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d      = state_q;
      cpu_stall_o  = 1'b0;
      cpu_data_o   = '0;
      mem_enable_o = 1'b0;
      mem_write_o  = 1'b0;
      mem_addr_o   = '0;
      mem_data_o   = '0;
      we           = 1'b0;
      wtag         = '0;
      wline        = rline;
      hit_evt      = 1'b0;
      miss_evt     = 1'b0;

      // Reset forces every output low even with a request pending.
      if (!rst_i) begin
         unique case (state_q)
            IDLE, RETRY: begin
               if (req && (hit || state_q == RETRY)) begin
                  hit_evt = 1'b1;
                  if (is_store) begin
                     we    = 1'b1;
                     wtag  = '{valid: 1'b1, dirty: 1'b1, tag: req_tag};
                     wline = merged;
                  end else begin
                     cpu_data_o = rword;
                  end
               end else if (req) begin
                  cpu_stall_o = 1'b1;
                  miss_evt    = 1'b1;
                  state_d     = MISS;
               end
               if (state_q == RETRY) state_d = IDLE;
            end
            MISS: begin
               cpu_stall_o = 1'b1;
               state_d = (rtag.valid && rtag.dirty) ? WRITEBACK : ALLOCATE;
            end
            WRITEBACK: begin
               cpu_stall_o  = 1'b1;
               mem_enable_o = 1'b1;
               mem_write_o  = 1'b1;
               mem_addr_o   = victim_addr;
               mem_data_o   = rline;
               if (mem_ack_i) state_d = ALLOCATE;
            end
            ALLOCATE: begin
               cpu_stall_o  = 1'b1;
               mem_enable_o = 1'b1;
               mem_addr_o   = fill_addr;
               if (mem_ack_i) begin
                  we      = 1'b1;
                  wtag    = '{valid: 1'b1, dirty: 1'b0, tag: req_tag};
                  wline   = mem_data_i;
                  state_d = RETRY;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

`ifdef DCACHE_STATS_EN
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         hit_count_o  <= '0;
         miss_count_o <= '0;
      end else begin
         if (hit_evt && hit_count_o != 32'hFFFF_FFFF)
            hit_count_o <= hit_count_o + 32'd1;
         if (miss_evt && miss_count_o != 32'hFFFF_FFFF)
            miss_count_o <= miss_count_o + 32'd1;
      end
   end
`else
   logic unused_stats;
   assign unused_stats = hit_evt ^ miss_evt;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: hit vectors from a table plus
// hand-written miss, write-back, delayed-ack and reset sequences.
module tb_dcache_ctrl;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [31:0]  cpu_addr = '0;
   logic [31:0]  cpu_wdata = '0;
   logic         cpu_rd = 1'b0;
   logic         cpu_wr = 1'b0;
   logic [31:0]  cpu_rdata;
   logic         stall;
   logic [31:0]  mem_addr;
   logic [255:0] mem_wdata;
   logic         mem_en;
   logic         mem_we;
   logic [255:0] mem_rdata = '0;
   logic         mem_ack = 1'b0;
`ifdef DCACHE_STATS_EN
   logic [31:0]  hit_count;
   logic [31:0]  miss_count;
`endif

   int n_run  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   dcache_ctrl #(
      .LINES     (32),
      .LINE_BITS (256)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .cpu_addr_i   (cpu_addr),
      .cpu_data_i   (cpu_wdata),
      .cpu_MemRd_i  (cpu_rd),
      .cpu_MemWr_i  (cpu_wr),
      .cpu_data_o   (cpu_rdata),
      .cpu_stall_o  (stall),
      .mem_addr_o   (mem_addr),
      .mem_data_o   (mem_wdata),
      .mem_enable_o (mem_en),
      .mem_write_o  (mem_we),
      .mem_data_i   (mem_rdata),
      .mem_ack_i    (mem_ack)
`ifdef DCACHE_STATS_EN
      ,
      .hit_count_o  (hit_count),
      .miss_count_o (miss_count)
`endif
   );

   typedef struct {
      string       name;
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        exp_stall;
      logic [31:0] exp_data;
   } vec_t;

   vec_t vt[8];

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [255:0] mk_line(input logic [31:0] base);
      logic [255:0] l;
      for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + 32'(i);
      return l;
   endfunction

   task automatic apply(input int i);
      cpu_rd    = vt[i].rd;
      cpu_wr    = vt[i].wr;
      cpu_addr  = vt[i].addr;
      cpu_wdata = vt[i].wdata;
      @(negedge clk);
      chk({vt[i].name, "_stall"}, 64'(stall), 64'(vt[i].exp_stall));
      chk({vt[i].name, "_data"}, 64'(cpu_rdata), 64'(vt[i].exp_data));
      chk({vt[i].name, "_men"}, 64'(mem_en), 64'd0);
      tick();
   endtask

   task automatic wait_en(input string name);
      for (int k = 0; k < 10 && !mem_en; k++) tick();
      chk({name, "_wait_en"}, 64'(mem_en), 64'd1);
   endtask

   task automatic idle_cpu();
      cpu_rd = 1'b0;
      cpu_wr = 1'b0;
   endtask

   initial begin
      vt[0] = '{"st404",   1'b0, 1'b1, 32'h404, 32'hDEADBEEF, 1'b0, 32'h0};
      vt[1] = '{"ld404",   1'b1, 1'b0, 32'h404, 32'h0,        1'b0, 32'hDEADBEEF};
      vt[2] = '{"ld800",   1'b1, 1'b0, 32'h800, 32'h0,        1'b0, 32'hB0000000};
      vt[3] = '{"ld81c",   1'b1, 1'b0, 32'h81C, 32'h0,        1'b0, 32'hB0000007};
      vt[4] = '{"rdwr808", 1'b1, 1'b1, 32'h808, 32'h12345678, 1'b0, 32'h0};
      vt[5] = '{"ld808",   1'b1, 1'b0, 32'h808, 32'h0,        1'b0, 32'h12345678};
      vt[6] = '{"nop808",  1'b0, 1'b0, 32'h808, 32'h0,        1'b0, 32'h0};
      vt[7] = '{"ld80c",   1'b1, 1'b0, 32'h80C, 32'h0,        1'b0, 32'hB0000003};

      // reset holds every output low even with a request present
      cpu_rd   = 1'b1;
      cpu_addr = 32'h404;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_stall", 64'(stall), 64'd0);
      chk("rst_men", 64'(mem_en), 64'd0);
      chk("rst_mwe", 64'(mem_we), 64'd0);
      chk("rst_maddr", 64'(mem_addr), 64'd0);
      chk("rst_mdata", 64'(mem_wdata[63:0]), 64'd0);
      chk("rst_cdata", 64'(cpu_rdata), 64'd0);
      tick();
      rst = 1'b0;
      idle_cpu();

      // stray ack in IDLE does nothing
      mem_ack = 1'b1;
      @(negedge clk);
      chk("idle_ack", 64'({mem_en, stall}), 64'd0);
      tick();
      mem_ack = 1'b0;

      // cold load with ack delayed ten cycles
      cpu_rd   = 1'b1;
      cpu_addr = 32'h404;
      @(negedge clk);
      chk("cold_stall", 64'(stall), 64'd1);
      tick();
      wait_en("cold");
      chk("cold_addr", 64'(mem_addr), 64'h400);
      chk("cold_mwe", 64'(mem_we), 64'd0);
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("cold_hold", {31'd0, mem_en, stall, mem_addr},
             {31'd0, 1'b1, 1'b1, 32'h400});
      end
      mem_rdata = mk_line(32'hA000_0000);
      mem_ack   = 1'b1;
      tick();
      mem_ack = 1'b0;
      @(negedge clk);
      chk("cold_retry_stall", 64'(stall), 64'd0);
      chk("cold_retry_data", 64'(cpu_rdata), 64'hA0000001);
      chk("cold_retry_men", 64'(mem_en), 64'd0);
      tick();
      idle_cpu();

      apply(0);
      apply(1);

      // dirty conflict: write-back of 0x400 before fill of 0x800
      cpu_rd   = 1'b1;
      cpu_addr = 32'h804;
      @(negedge clk);
      chk("conf_stall", 64'(stall), 64'd1);
      tick();
      wait_en("wb");
      @(negedge clk);
      chk("wb_mwe", 64'(mem_we), 64'd1);
      chk("wb_addr", 64'(mem_addr), 64'h400);
      chk("wb_w1", 64'(mem_wdata[63:32]), 64'hDEADBEEF);
      chk("wb_w0", 64'(mem_wdata[31:0]), 64'hA0000000);
      chk("wb_w7", 64'(mem_wdata[255:224]), 64'hA0000007);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      @(negedge clk);
      chk("al_men", 64'(mem_en), 64'd1);
      chk("al_mwe", 64'(mem_we), 64'd0);
      chk("al_addr", 64'(mem_addr), 64'h800);
      chk("al_stall", 64'(stall), 64'd1);
      mem_rdata = mk_line(32'hB000_0000);
      mem_ack   = 1'b1;
      tick();
      mem_ack = 1'b0;
      @(negedge clk);
      chk("conf_retry_stall", 64'(stall), 64'd0);
      chk("conf_retry_data", 64'(cpu_rdata), 64'hB0000001);
      tick();
      idle_cpu();
`ifdef DCACHE_STATS_EN
      @(negedge clk);
      chk("hit_count", 64'(hit_count), 64'd4);
      chk("miss_count", 64'(miss_count), 64'd2);
      tick();
`endif

      for (int i = 2; i < 8; i++) apply(i);

      // reset during ALLOCATE abandons the fill and drops mem_enable at once
      cpu_rd   = 1'b1;
      cpu_addr = 32'h120;
      tick();
      wait_en("rst_al");
      @(negedge clk);
      chk("rst_al_addr", 64'(mem_addr), 64'h120);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_men", 64'(mem_en), 64'd0);
      chk("arst_stall", 64'(stall), 64'd0);
      chk("arst_addr", 64'(mem_addr), 64'd0);
      mem_rdata = mk_line(32'hC000_0000);
      mem_ack   = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_miss", 64'(stall), 64'd1);
      chk("post_rst_men", 64'(mem_en), 64'd0);
      tick();
      mem_ack = 1'b0;
      @(negedge clk);
      chk("late_ack_ignored", 64'({mem_en, stall}), 64'b01);
      tick();
      wait_en("refill");
      chk("refill_addr", 64'(mem_addr), 64'h120);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      @(negedge clk);
      chk("refill_data", 64'(cpu_rdata), 64'hC0000000);
      tick();

      // line 0 was invalidated by reset
      cpu_addr = 32'h808;
      @(negedge clk);
      chk("inval_miss", 64'(stall), 64'd1);
      tick();
      idle_cpu();
      repeat (3) tick();
      rst = 1'b1;
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("final_idle", 64'({mem_en, stall}), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 Parameter LINES, default 32: number of direct-mapped cache lines (power of 2).
REQ-002 Parameter LINE_BITS, default 256: line width in bits (8 words).
REQ-003 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_i  input  1  asynchronous, active-high reset.
REQ-005 cpu_addr_i  input  32  byte address from MEM-stage ALU result.
REQ-006 cpu_data_i  input  32  store data from MEM stage.
REQ-007 cpu_MemRd_i / cpu_MemWr_i  input  1 each  load / store request.
REQ-008 cpu_data_o  output  32  load data; cpu_stall_o  output  1  freeze entire pipeline.
REQ-009 mem_addr_o  output  32  line-aligned off-chip address; mem_data_o  output  LINE_BITS  write-back line.
REQ-010 mem_enable_o / mem_write_o  output  1 each  off-chip request / write qualifier.
REQ-011 mem_data_i  input  LINE_BITS  fill line; mem_ack_i  input  1  one-cycle completion pulse.

Function
REQ-012 Address split: offset [4:0], word select [4:2], index [4+log2(LINES):5], tag = remaining upper bits.
REQ-013 Policy: write-back, write-allocate; per-line valid, dirty, tag.
REQ-014 Hit = request active, line valid, tag equal; evaluated combinationally in IDLE.
REQ-015 Load hit: cpu_data_o = selected word in the same cycle; cpu_stall_o = 0; zero added latency.
REQ-016 Store hit: word written at next edge; dirty set; cpu_stall_o = 0.
REQ-017 Miss: cpu_stall_o = 1 in the same cycle; held high until the retried access hits.
REQ-018 FSM states: IDLE, MISS, WRITEBACK, ALLOCATE, RETRY.
REQ-019 IDLE->MISS on miss; MISS->WRITEBACK if victim valid and dirty, else MISS->ALLOCATE.
REQ-020 WRITEBACK: mem_enable_o = 1, mem_write_o = 1, mem_addr_o = {victim tag, index, 5'b0}, mem_data_o = victim line; on mem_ack_i -> ALLOCATE.
REQ-021 ALLOCATE: mem_enable_o = 1, mem_write_o = 0, mem_addr_o = {req tag, index, 5'b0}; on mem_ack_i: line = mem_data_i, valid = 1, dirty = 0, tag updated -> RETRY.
REQ-022 RETRY: one-cycle re-lookup (guaranteed hit) -> IDLE; cpu_stall_o drops in RETRY.
REQ-023 mem_enable_o is held, with stable address and data, until mem_ack_i; mem_ack_i outside WRITEBACK/ALLOCATE is ignored.
REQ-024 CPU holds address, data, and strobes stable while cpu_stall_o = 1.
REQ-025 Rd and Wr both high: treated as a store.
REQ-026 Neither strobe high: no state change; cpu_stall_o = 0; cpu_data_o = 0.

Reset
REQ-027 rst_i asserted: FSM = IDLE; all valid/dirty = 0; cpu_stall_o, mem_enable_o, mem_write_o = 0; mem_addr_o, mem_data_o, cpu_data_o = 0.
REQ-028 Reset mid-miss: the in-flight transfer is abandoned immediately; a late mem_ack_i is ignored; data array contents are don't-care.

Configuration
REQ-029 Macro DCACHE_STATS_EN defined: adds outputs hit_count_o and miss_count_o (32-bit each). Each counter increments once per completed access or per miss, saturates at 32'hFFFFFFFF, and clears on reset.
REQ-030 Macro absent: the counters and their ports do not exist; all other behaviour is identical.

Structure
REQ-031 Shared package dcache_pkg holds: FSM state enum, OFFSET_W/INDEX_W/TAG_W constants, and the tag-entry struct {valid, dirty, tag}.
REQ-032 Sub-module dcache_sram (tag + data arrays, single port, synchronous write) is instantiated once; the FSM and hit logic stay in dcache_ctrl.

Verification
REQ-033 Cold load 0x0000_0404 -> stall, ALLOCATE at 0x0000_0400; after mem_ack_i, cpu_data_o = word 1 of the fill; stall low in RETRY.
REQ-034 Store 0xDEADBEEF to 0x404, then load 0x404 -> no stall on either; load returns 0xDEADBEEF.
REQ-035 Dirty conflict: load 0x0000_0804 (same index, new tag) -> WRITEBACK of 0x400 line (containing 0xDEADBEEF) precedes ALLOCATE of 0x800.
REQ-036 mem_ack_i delayed 10 cycles -> mem_enable_o and mem_addr_o stay stable; stall stays high throughout.
REQ-037 rst_i pulsed during ALLOCATE -> mem_enable_o = 0 asynchronously; next load to the same address misses.
REQ-038 DCACHE_STATS_EN defined, sequence from REQ-033 to REQ-035 -> hit_count_o = 4, miss_count_o = 2. Hits = 4 because each retry counts as a hit and the REQ-034 store and load are hits; misses are the cold load and the conflict load.
